// File: rtl/fir_coef_mac_pkg.sv
// Shared types and sizing helpers for the fir_coef_mac engine.
// The FIR_ROUND_SAT_EN macro is consumed by the top module only.
package fir_coef_mac_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Select width that stays legal for a single-entry delay line.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Full-precision accumulator width: NTAPS products of DW x CW bits.
  function automatic int acc_width(input int dw, input int cw, input int ntaps);
    return dw + cw + $clog2(ntaps);
  endfunction

endpackage

// File: rtl/fir_coef_mac_delay_line.sv
// NTAPS-deep sample shift register with shift enable, synchronous clear
// and a combinational tap-select read port.
module fir_coef_mac_delay_line #(
  parameter int NTAPS = 8,
  parameter int DW    = 16,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             shift_en,
  input  logic [DW-1:0]    din,
  input  logic [SEL_W-1:0] sel,
  output logic [DW-1:0]    tap
);

  logic [DW-1:0] taps [NTAPS];

  genvar gi;
  generate
    for (gi = 0; gi < NTAPS; gi++) begin : g_stage
      logic [DW-1:0] x_reg;
      logic [DW-1:0] x_next;

      if (gi == 0) begin : g_head
        assign x_next = din;
      end else begin : g_body
        assign x_next = taps[gi-1];
      end

      always_ff @(posedge clk) begin
        if (clear) begin
          x_reg <= '0;
        end else if (shift_en) begin
          x_reg <= x_next;
        end
      end

      assign taps[gi] = x_reg;
    end
  endgenerate

  // Non-power-of-two depths leave unused select codes; read them as zero.
  assign tap = (sel <= SEL_W'(NTAPS - 1)) ? taps[sel] : '0;

endmodule

// File: rtl/fir_coef_mac.sv
// Per-sample FIR MAC engine reading its coefficients from an external SRAM.
// Optional FIR_ROUND_SAT_EN: round half-up and saturate the result to DW bits.
module fir_coef_mac
  import fir_coef_mac_pkg::*;
#(
  parameter int NTAPS     = 8,
  parameter int DW        = 16,
  parameter int CW        = 16,
  parameter int AW        = 6,
  parameter int COEF_BASE = 0,
  parameter int ACC_W     = acc_width(DW, CW, NTAPS),
`ifdef FIR_ROUND_SAT_EN
  localparam int OUT_W    = DW
`else
  localparam int OUT_W    = ACC_W
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [DW-1:0]    in_data,
  output logic             mem_cen,
  output logic             mem_wen,
  output logic [AW-1:0]    mem_a,
  input  logic [CW-1:0]    mem_q,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data
);

  localparam int K_W    = $clog2(NTAPS + 1);
  localparam int SEL_W  = clog2_min1(NTAPS);
  localparam int PROD_W = DW + CW;

  state_t state_reg, state_next;

  logic [K_W-1:0]          k_reg;
  logic signed [ACC_W-1:0] acc_reg;
  logic                    in_ready_reg;
  logic                    out_valid_reg;
  logic [OUT_W-1:0]        out_data_reg;
  logic                    mem_cen_reg, mem_cen_next;
  logic [AW-1:0]           mem_a_reg, mem_a_next;

  logic                     accept;
  logic                     last_cyc;
  logic                     release_out;
  logic [SEL_W-1:0]         tap_sel;
  logic [DW-1:0]            tap;
  logic signed [PROD_W-1:0] prod;
  logic [OUT_W-1:0]         result;

  assign accept      = (state_reg == S_IDLE) && in_valid && in_ready_reg;
  assign last_cyc    = (k_reg == K_W'(NTAPS));
  assign release_out = out_valid_reg && out_ready;

  // Cycle k of RUN consumes the coefficient addressed in cycle k-1.
  assign tap_sel = SEL_W'(k_reg - K_W'(1));
  assign prod    = $signed(mem_q) * $signed(tap);

  fir_coef_mac_delay_line #(
    .NTAPS (NTAPS),
    .DW    (DW),
    .SEL_W (SEL_W)
  ) u_delay_line (
    .clk      (CLK),
    .clear    (RST),
    .shift_en (accept),
    .din      (in_data),
    .sel      (tap_sel),
    .tap      (tap)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (accept)      state_next = S_RUN;
      S_RUN:   if (last_cyc)    state_next = S_DONE;
      S_DONE:  if (release_out) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Address generation: COEF_BASE on accept, then one word per RUN cycle.
  always_comb begin
    mem_cen_next = mem_cen_reg;
    mem_a_next   = mem_a_reg;
    if (accept) begin
      mem_cen_next = 1'b0;
      mem_a_next   = AW'(COEF_BASE);
    end else if (state_reg == S_RUN) begin
      if (k_reg < K_W'(NTAPS - 1)) begin
        mem_a_next = AW'(COEF_BASE) + AW'(k_reg) + AW'(1);
      end else begin
        mem_cen_next = 1'b1;
      end
    end
  end

`ifdef FIR_ROUND_SAT_EN
  localparam int RND_W = ACC_W + 1;
  localparam logic signed [RND_W-1:0] ROUND_HALF = RND_W'(1) <<< (CW - 2);
  localparam logic signed [RND_W-1:0] SAT_MAX    = (RND_W'(1) <<< (DW - 1)) - RND_W'(1);
  localparam logic signed [RND_W-1:0] SAT_MIN    = -(RND_W'(1) <<< (DW - 1));

  logic signed [RND_W-1:0] rnd_sum;
  logic signed [RND_W-1:0] rnd_shift;

  assign rnd_sum   = RND_W'(acc_reg) + ROUND_HALF;
  assign rnd_shift = rnd_sum >>> (CW - 1);

  always_comb begin
    result = rnd_shift[OUT_W-1:0];
    if (rnd_shift > SAT_MAX) begin
      result = SAT_MAX[OUT_W-1:0];
    end else if (rnd_shift < SAT_MIN) begin
      result = SAT_MIN[OUT_W-1:0];
    end
  end
`else
  always_comb begin
    result = acc_reg;
  end
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= S_IDLE;
      k_reg         <= '0;
      acc_reg       <= '0;
      in_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      mem_cen_reg   <= 1'b1;
      mem_a_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      in_ready_reg <= (state_next == S_IDLE);
      mem_cen_reg  <= mem_cen_next;
      mem_a_reg    <= mem_a_next;
      case (state_reg)
        S_IDLE: begin
          if (accept) begin
            acc_reg <= '0;
            k_reg   <= '0;
          end
        end
        S_RUN: begin
          if (!last_cyc) begin
            k_reg <= k_reg + K_W'(1);
          end
          if (k_reg != '0) begin
            acc_reg <= acc_reg + ACC_W'(prod);
          end
        end
        S_DONE: begin
          // First DONE cycle latches the result; it then holds until taken.
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= result;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign mem_cen   = mem_cen_reg;
  assign mem_wen   = 1'b1;
  assign mem_a     = mem_a_reg;

endmodule

// File: tb/tb_fir_coef_mac.sv
// Self-checking bench for fir_coef_mac: default instance plus a
// NTAPS=4 / COEF_BASE=16 instance, each with a behavioural SRAM model.
module tb_fir_coef_mac;

  localparam int NTAPS  = 8;
  localparam int DW     = 16;
  localparam int CW     = 16;
  localparam int AW     = 6;
  localparam int ACC_W  = DW + CW + $clog2(NTAPS);
  localparam int NTAPS6 = 4;
  localparam int BASE6  = 16;
  localparam int ACC_W6 = DW + CW + $clog2(NTAPS6);
`ifdef FIR_ROUND_SAT_EN
  localparam int OUT_W  = DW;
  localparam int OUT_W6 = DW;
`else
  localparam int OUT_W  = ACC_W;
  localparam int OUT_W6 = ACC_W6;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // Default instance and its SRAM (host port muxed in for loading)
  logic             in_valid, in_ready, mem_cen, mem_wen, out_valid, out_ready;
  logic [DW-1:0]    in_data;
  logic [AW-1:0]    mem_a;
  logic [CW-1:0]    mem_q;
  logic [OUT_W-1:0] out_data;

  logic          host_sel, host_cen, host_wen;
  logic [AW-1:0] host_a;
  logic [CW-1:0] host_d;
  logic          sram_cen, sram_wen;
  logic [AW-1:0] sram_a;
  logic [CW-1:0] sram [64];

  assign sram_cen = host_sel ? host_cen : mem_cen;
  assign sram_wen = host_sel ? host_wen : mem_wen;
  assign sram_a   = host_sel ? host_a   : mem_a;

  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_wen) sram[sram_a] <= host_d;
      else           mem_q <= sram[sram_a];
    end
  end

  fir_coef_mac #(.NTAPS(NTAPS), .DW(DW), .CW(CW), .AW(AW), .COEF_BASE(0)) dut (
    .CLK(clk), .RST(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_a(mem_a), .mem_q(mem_q),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  // Second instance: 4 taps at base 16, poison words elsewhere
  logic              in_valid6, in_ready6, mem_cen6, mem_wen6, out_valid6, out_ready6;
  logic [DW-1:0]     in_data6;
  logic [AW-1:0]     mem_a6;
  logic [CW-1:0]     mem_q6;
  logic [OUT_W6-1:0] out_data6;
  logic [CW-1:0]     mem6 [64];

  always @(posedge clk) begin
    if (!mem_cen6) mem_q6 <= mem6[mem_a6];
  end

  fir_coef_mac #(.NTAPS(NTAPS6), .DW(DW), .CW(CW), .AW(AW), .COEF_BASE(BASE6)) dut6 (
    .CLK(clk), .RST(rst),
    .in_valid(in_valid6), .in_ready(in_ready6), .in_data(in_data6),
    .mem_cen(mem_cen6), .mem_wen(mem_wen6), .mem_a(mem_a6), .mem_q(mem_q6),
    .out_valid(out_valid6), .out_ready(out_ready6), .out_data(out_data6)
  );

  // Reference model and scoreboards
  logic signed [CW-1:0] coef [NTAPS];
  longint               mx [NTAPS];
  logic signed [CW-1:0] coef6 [NTAPS6];
  longint               mx6 [NTAPS6];
  longint               exp_q[$];
  longint               exp6_q[$];
  int                   addr6_q[$];
  longint               mon_e, mon_e6;
  int                   n_cmp = 0;
  int                   n_fail = 0;
  int                   n_out = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint model_sum();
    longint s = 0;
    for (int k = 0; k < NTAPS; k++) s += longint'(coef[k]) * mx[k];
    return s;
  endfunction

  function automatic longint model_sum6();
    longint s = 0;
    for (int k = 0; k < NTAPS6; k++) s += longint'(coef6[k]) * mx6[k];
    return s;
  endfunction

  function automatic longint to_out(input longint acc);
`ifdef FIR_ROUND_SAT_EN
    longint r;
    longint hi;
    r  = (acc + (longint'(1) <<< (CW - 2))) >>> (CW - 1);
    hi = (longint'(1) <<< (DW - 1)) - 1;
    if (r > hi) r = hi;
    else if (r < -hi - 1) r = -hi - 1;
    return r;
`else
    return acc;
`endif
  endfunction

  // Handshake monitors: inputs change 1ns after posedge, so negedge sees the next edge's view
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", longint'(exp_q.size()), 1);
      end else begin
        mon_e = exp_q.pop_front();
        $display("out #%0d: got %0d expect %0d", n_out, longint'($signed(out_data)), mon_e);
        check("out_data", longint'($signed(out_data)), mon_e);
        n_out++;
      end
    end
    if (!rst && out_valid6 && out_ready6) begin
      if (exp6_q.size() == 0) begin
        check("sb6_underflow", longint'(exp6_q.size()), 1);
      end else begin
        mon_e6 = exp6_q.pop_front();
        $display("out6: got %0d expect %0d", longint'($signed(out_data6)), mon_e6);
        check("out_data6", longint'($signed(out_data6)), mon_e6);
      end
    end
    if (!rst && !mem_cen6) addr6_q.push_back(int'(mem_a6));
  end

  task automatic load_coef(input int k, input logic signed [CW-1:0] v);
    host_sel = 1'b1; host_cen = 1'b0; host_wen = 1'b0;
    host_a = AW'(k); host_d = v;
    tick();
    host_cen = 1'b1; host_wen = 1'b1; host_sel = 1'b0;
    coef[k] = v;
  endtask

  task automatic send(input logic [DW-1:0] s);
    int t = 0;
    while (!in_ready && t < 100) begin tick(); t++; end
    if (!in_ready) check("send_wait_in_ready", longint'(in_ready), 1);
    in_valid = 1'b1; in_data = s;
    tick();
    in_valid = 1'b0;
    for (int k = NTAPS - 1; k > 0; k--) mx[k] = mx[k-1];
    mx[0] = longint'($signed(s));
  endtask

  task automatic send6(input logic [DW-1:0] s);
    int t = 0;
    while (!in_ready6 && t < 100) begin tick(); t++; end
    if (!in_ready6) check("send6_wait_in_ready", longint'(in_ready6), 1);
    in_valid6 = 1'b1; in_data6 = s;
    tick();
    in_valid6 = 1'b0;
    for (int k = NTAPS6 - 1; k > 0; k--) mx6[k] = mx6[k-1];
    mx6[0] = longint'($signed(s));
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || exp6_q.size() != 0) && t < 500) begin tick(); t++; end
    check("drain_pending", longint'(exp_q.size()), 0);
    check("drain_pending6", longint'(exp6_q.size()), 0);
  endtask

  typedef struct {
    logic [DW-1:0] x;
    longint        acc;
  } vec_t;
  vec_t tab [8];

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected self-termination");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int     t;
    int     lat;
    int     low;
    longint held;

    for (int i = 0; i < 8; i++) begin
      tab[i].x   = (i == 0) ? DW'(1) : DW'(0);
      tab[i].acc = longint'(i + 1);
    end
    for (int k = 0; k < NTAPS; k++) begin coef[k] = '0; mx[k] = 0; end
    for (int i = 0; i < 64; i++) mem6[i] = 16'h7fff;
    coef6[0] = 16'sd3; coef6[1] = -16'sd5; coef6[2] = 16'sd7; coef6[3] = 16'sd11;
    for (int k = 0; k < NTAPS6; k++) begin mem6[BASE6 + k] = coef6[k]; mx6[k] = 0; end

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    in_valid6 = 1'b0; in_data6 = '0; out_ready6 = 1'b1;
    host_sel = 1'b1; host_cen = 1'b1; host_wen = 1'b1; host_a = '0; host_d = '0;
    repeat (3) tick();

    // Reset state
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_out_data", longint'(out_data), 0);
    check("rst_mem_cen", longint'(mem_cen), 1);
    check("rst_mem_wen", longint'(mem_wen), 1);
    check("rst_mem_a", longint'(mem_a), 0);
    rst = 1'b0;
    host_sel = 1'b0;
    tick();

    for (int k = 0; k < NTAPS; k++) load_coef(k, CW'(k + 1));

    // Offset base, 4 taps: addresses confined to 16..19
    send6(DW'(100));  exp6_q.push_back(to_out(model_sum6()));
    send6(-DW'(200)); exp6_q.push_back(to_out(model_sum6()));
    send6(DW'(300));  exp6_q.push_back(to_out(model_sum6()));
    drain();
    check("addr6_count", longint'(addr6_q.size()), 3 * NTAPS6);
    for (int i = 0; i < addr6_q.size(); i++) check("addr6_value", longint'(addr6_q[i]), BASE6 + (i % NTAPS6));

    // Impulse response from the table
    for (int i = 0; i < 8; i++) begin
      send(tab[i].x);
      exp_q.push_back(to_out(tab[i].acc));
    end
    drain();

    // Latency and in_ready low window
    send(DW'(3));
    exp_q.push_back(to_out(model_sum()));
    lat = -1; low = 0; t = 0;
    while (t < 40 && !(lat >= 0 && in_ready)) begin
      if (!in_ready) low++;
      if (lat < 0 && out_valid) lat = t;
      tick(); t++;
    end
    check("latency", longint'(lat), NTAPS + 2);
    check("in_ready_low_cycles", longint'(low), NTAPS + 3);
    drain();

    // Backpressure in DONE: result held, offered samples ignored
    out_ready = 1'b0;
    send(-DW'(7));
    exp_q.push_back(to_out(model_sum()));
    t = 0;
    while (!out_valid && t < 50) begin tick(); t++; end
    check("bp_out_valid_rise", longint'(out_valid), 1);
    held = longint'($signed(out_data));
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_data = DW'(16'h1234);
      tick();
      check("bp_out_data_stable", longint'($signed(out_data)), held);
      check("bp_in_ready_low", longint'(in_ready), 0);
      check("bp_out_valid_held", longint'(out_valid), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_release_in_ready", longint'(in_ready), 1);
    check("bp_release_out_valid", longint'(out_valid), 0);

    // Mixed samples through the full history
    for (int i = 0; i < 6; i++) begin
      send(DW'($urandom()));
      exp_q.push_back(to_out(model_sum()));
    end
    drain();

    // Signed extreme: c[0]=-32768 only, x=-32768 -> 2^30
    load_coef(0, -CW'(32768));
    for (int k = 1; k < NTAPS; k++) load_coef(k, CW'(0));
    send(DW'(16'h8000));
    exp_q.push_back(to_out(longint'(1) <<< 30));
    drain();

    // All coefficients and samples at the positive maximum
    for (int k = 0; k < NTAPS; k++) load_coef(k, CW'(32767));
    for (int i = 0; i < NTAPS; i++) begin
      send(DW'(32767));
      exp_q.push_back(to_out(model_sum()));
    end
    drain();

    // Reset during RUN: result dropped, delay line cleared
    for (int k = 0; k < NTAPS; k++) load_coef(k, CW'(k + 1));
    send(DW'(5));
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_mem_cen", longint'(mem_cen), 1);
    check("midrst_out_valid", longint'(out_valid), 0);
    check("midrst_in_ready", longint'(in_ready), 0);
    for (int k = 0; k < NTAPS; k++) mx[k] = 0;
    t = 0;
    while (t < 20 && !out_valid) begin tick(); t++; end
    check("midrst_no_stale_out", longint'(out_valid), 0);
    send(DW'(1));
    exp_q.push_back(to_out(1));
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
